// File: rtl/keypad_scan4x4.sv
// keypad_scan4x4 -- 4x4 matrix keypad scanner with debounce and a valid/ready
// key output.
//
// One column strobe is driven low at a time. Each column is held for SCAN_DIV
// clocks (one dwell). The synchronized row returns are sampled once per dwell,
// on its last cycle. A press is accepted after DEBOUNCE_N consecutive low
// samples, and a release after DEBOUNCE_N consecutive high samples.
//
// Ports
//   clk        system clock, rising edge
//   rst_n      synchronous active-low reset
//   col_n[3:0] column strobes, active-low, exactly one low
//   row_n[3:0] row returns, active-low, asynchronous to clk
//   key_code   accepted key, {row[1:0], col[1:0]}
//   key_valid  key_code holds a key not yet taken by the consumer
//   key_ready  consumer takes key_code while key_valid is high
//   key_held   the accepted key is still pressed
//   overrun    one-cycle pulse: a key was accepted while key_valid was high
module keypad_scan4x4 #(
  parameter int SCAN_DIV   = 50000,
  parameter int DEBOUNCE_N = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [3:0] col_n,
  input  logic [3:0] row_n,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ready,
  output logic       key_held,
  output logic       overrun
);

  localparam int               CNT_W      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [7:0]       DBC_LAST   = 8'(DEBOUNCE_N);

  typedef enum logic [1:0] {S_SCAN, S_DEBOUNCE, S_HELD, S_RELEASE} state_t;

  state_t           r_state;
  logic [3:0]       r_sync1;
  logic [3:0]       r_sync2;
  logic [CNT_W-1:0] r_dwell;
  logic [1:0]       r_col;
  logic [1:0]       r_row;
  logic [7:0]       r_dbc;
  logic [7:0]       r_rc;
  logic [3:0]       r_col_n;
  logic [3:0]       r_key_code;
  logic             r_key_valid;
  logic             r_key_held;
  logic             r_overrun;

  logic       w_dwell_end;
  logic       w_any_low;
  logic [1:0] w_low_row;
  logic       w_row_low;
  logic [1:0] w_col_next;
  logic       w_accept;
  logic [3:0] w_accept_code;
  logic       w_release_done;

  // Lowest-index row that is pulled low; only meaningful when some row is low.
  function automatic logic [1:0] lowest_low(input logic [3:0] rows);
    lowest_low = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!rows[i]) lowest_low = 2'(i);
    end
  endfunction

  function automatic logic [3:0] col_strobe(input logic [1:0] c);
    return ~(4'b0001 << c);
  endfunction

  always_comb begin
    w_dwell_end = (r_dwell == DWELL_LAST);
    w_any_low   = ~&r_sync2;
    w_low_row   = lowest_low(r_sync2);
    w_row_low   = ~r_sync2[r_row];
    w_col_next  = r_col + 2'd1;
    // With DEBOUNCE_N == 1 the detecting sample is already the accepting one,
    // and likewise the first high sample in HELD completes the release.
    w_accept = w_dwell_end &&
               (((r_state == S_SCAN) && w_any_low && (DEBOUNCE_N == 1)) ||
                ((r_state == S_DEBOUNCE) && w_row_low && ((r_dbc + 8'd1) == DBC_LAST)));
    w_accept_code = (r_state == S_SCAN) ? {w_low_row, r_col} : {r_row, r_col};
    w_release_done = w_dwell_end && !w_row_low &&
                     (((r_state == S_HELD) && (DEBOUNCE_N == 1)) ||
                      ((r_state == S_RELEASE) && ((r_rc + 8'd1) == DBC_LAST)));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_SCAN;
      r_sync1     <= 4'hF;
      r_sync2     <= 4'hF;
      r_dwell     <= '0;
      r_col       <= 2'd0;
      r_row       <= 2'd0;
      r_dbc       <= 8'd0;
      r_rc        <= 8'd0;
      r_col_n     <= 4'b1110;
      r_key_code  <= 4'd0;
      r_key_valid <= 1'b0;
      r_key_held  <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_sync1   <= row_n;
      r_sync2   <= r_sync1;
      r_dwell   <= w_dwell_end ? '0 : r_dwell + CNT_W'(1);
      r_overrun <= 1'b0;

      if (r_key_valid && key_ready) r_key_valid <= 1'b0;

      // A key accepted while the previous one is still unread is dropped.
      if (w_accept) begin
        if (!r_key_valid) begin
          r_key_code  <= w_accept_code;
          r_key_valid <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end

      if (w_dwell_end) begin
        case (r_state)
          S_SCAN: begin
            if (w_any_low) begin
              r_row <= w_low_row;
              r_dbc <= 8'd1;
              if (w_accept) begin
                r_state    <= S_HELD;
                r_key_held <= 1'b1;
              end else begin
                r_state <= S_DEBOUNCE;
              end
            end else begin
              r_col   <= w_col_next;
              r_col_n <= col_strobe(w_col_next);
            end
          end
          S_DEBOUNCE: begin
            if (w_row_low) begin
              r_dbc <= r_dbc + 8'd1;
              if (w_accept) begin
                r_state    <= S_HELD;
                r_key_held <= 1'b1;
              end
            end else begin
              r_state <= S_SCAN;
              r_col   <= w_col_next;
              r_col_n <= col_strobe(w_col_next);
            end
          end
          S_HELD: begin
            if (!w_row_low) begin
              r_rc <= 8'd1;
              if (w_release_done) begin
                r_state    <= S_SCAN;
                r_key_held <= 1'b0;
                r_col      <= w_col_next;
                r_col_n    <= col_strobe(w_col_next);
              end else begin
                r_state <= S_RELEASE;
              end
            end
          end
          S_RELEASE: begin
            if (w_row_low) begin
              r_state <= S_HELD;
            end else begin
              r_rc <= r_rc + 8'd1;
              if (w_release_done) begin
                r_state    <= S_SCAN;
                r_key_held <= 1'b0;
                r_col      <= w_col_next;
                r_col_n    <= col_strobe(w_col_next);
              end
            end
          end
          default: r_state <= S_SCAN;
        endcase
      end
    end
  end

  assign col_n     = r_col_n;
  assign key_code  = r_key_code;
  assign key_valid = r_key_valid;
  assign key_held  = r_key_held;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_keypad_scan4x4.sv
// Testbench for keypad_scan4x4: a keypad model drives row_n from the strobed
// column and the set of pressed keys; a cycle reference model derived from the
// scanning/debounce rules runs alongside and is compared every clock, next to
// table-driven and hand-written directed checks.
module tb_keypad_scan4x4;

  localparam int SCAN_DIV   = 4;
  localparam int DEBOUNCE_N = 3;

  logic       clk;
  logic       rst_n;
  logic [3:0] col_n;
  logic [3:0] row_n;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ready;
  logic       key_held;
  logic       overrun;

  keypad_scan4x4 #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_N(DEBOUNCE_N)) dut (
    .clk(clk), .rst_n(rst_n), .col_n(col_n), .row_n(row_n),
    .key_code(key_code), .key_valid(key_valid), .key_ready(key_ready),
    .key_held(key_held), .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  logic [15:0] keys = 16'h0;   // bit r*4+c = key at row r, column c pressed

  // ---------------- reference model ----------------
  int         m_cyc, m_state, m_col, m_row, m_cnt;   // state: 0 scan 1 deb 2 held 3 rel
  logic [3:0] m_code;
  logic       m_valid, m_held, m_ovr;
  logic [3:0] m_hist[$];                            // [0] newest row_n sample

  function automatic int first_low(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (!v[i]) return i;
    return -1;
  endfunction

  task automatic model_edge(input logic rst_v, input logic [3:0] rown, input logic rdy);
    logic [3:0] rs;
    logic       old_valid, acc, end_d;
    int         lr;
    if (!rst_v) begin
      m_cyc = 0; m_state = 0; m_col = 0; m_row = 0; m_cnt = 0;
      m_code = 4'h0; m_valid = 1'b0; m_held = 1'b0; m_ovr = 1'b0;
      m_hist = '{4'hF, 4'hF};
    end else begin
      rs = m_hist[1];                     // row_n as seen two edges ago
      m_hist.push_front(rown);
      void'(m_hist.pop_back());
      end_d = ((m_cyc % SCAN_DIV) == SCAN_DIV - 1);
      m_cyc++;
      old_valid = m_valid;
      m_ovr = 1'b0;
      acc = 1'b0;
      if (old_valid && rdy) m_valid = 1'b0;
      if (end_d) begin
        case (m_state)
          0: begin
            lr = first_low(rs);
            if (lr >= 0) begin
              m_row = lr; m_cnt = 1;
              if (m_cnt >= DEBOUNCE_N) begin acc = 1'b1; m_state = 2; end
              else m_state = 1;
            end else m_col = (m_col + 1) % 4;
          end
          1: begin
            if (!rs[m_row]) begin
              m_cnt++;
              if (m_cnt == DEBOUNCE_N) begin acc = 1'b1; m_state = 2; end
            end else begin m_state = 0; m_col = (m_col + 1) % 4; end
          end
          2: begin
            if (rs[m_row]) begin
              m_cnt = 1;
              if (m_cnt >= DEBOUNCE_N) begin m_state = 0; m_col = (m_col + 1) % 4; end
              else m_state = 3;
            end
          end
          default: begin
            if (rs[m_row]) begin
              m_cnt++;
              if (m_cnt == DEBOUNCE_N) begin m_state = 0; m_col = (m_col + 1) % 4; end
            end else m_state = 2;
          end
        endcase
      end
      m_held = (m_state == 2) || (m_state == 3);
      if (acc) begin
        if (old_valid) m_ovr = 1'b1;
        else begin m_code = 4'(m_row * 4 + m_col); m_valid = 1'b1; end
      end
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic drive_rows();
    logic [3:0] r;
    r = 4'hF;
    for (int ri = 0; ri < 4; ri++)
      for (int ci = 0; ci < 4; ci++)
        if (!col_n[ci] && keys[ri*4+ci]) r[ri] = 1'b0;
    row_n = r;
  endtask

  task automatic set_keys(input logic [15:0] k);
    keys = k;
    drive_rows();
  endtask

  task automatic tick();
    logic [3:0] ec;
    @(posedge clk);
    model_edge(rst_n, row_n, key_ready);
    #1;
    ec = 4'hF;
    ec[m_col] = 1'b0;
    n_chk++;
    if (col_n !== ec || key_code !== m_code || key_valid !== m_valid ||
        key_held !== m_held || overrun !== m_ovr) begin
      n_fail++;
      $display("FAIL model t=%0t col_n=%b/%b code=%h/%h valid=%b/%b held=%b/%b ovr=%b/%b (actual/required)",
               $time, col_n, ec, key_code, m_code, key_valid, m_valid, key_held, m_held, overrun, m_ovr);
    end
    drive_rows();
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    key_ready = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic wait_for(input string name, input bit on_held, input logic val, input int max);
    int n = 0;
    while (((on_held ? key_held : key_valid) !== val) && n < max) begin
      tick();
      n++;
    end
    chk(name, {15'd0, (on_held ? key_held : key_valid)}, {15'd0, val});
  endtask

  // ---------------- vector tables ----------------
  typedef struct {
    logic        rst_v;
    logic [15:0] k;
    logic        rdy;
    logic [3:0]  e_col_n;
    logic [3:0]  e_code;
    logic        e_valid;
    logic        e_held;
    logic        e_ovr;
  } vec_t;

  typedef struct {
    logic [15:0] k;
    logic [3:0]  code;
  } key_t;

  vec_t tbl[19];
  key_t ktbl[6];

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int ovr_cnt;
    logic [15:0] mask;
    int hold;
    int r;

    rst_n = 1'b0;
    key_ready = 1'b0;
    row_n = 4'hF;

    // Reset for two edges, then free scan with no key: four clocks per column.
    tbl[0]  = '{1'b0, 16'h0, 1'b0, 4'b1110, 4'h0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 16'h0, 1'b0, 4'b1110, 4'h0, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 16'h0, 1'b0, 4'b1110, 4'h0, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 16'h0, 1'b1, 4'b1110, 4'h0, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 16'h0, 1'b0, 4'b1110, 4'h0, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 16'h0, 1'b0, 4'b1101, 4'h0, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 16'h0, 1'b0, 4'b1101, 4'h0, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 16'h0, 1'b1, 4'b1101, 4'h0, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 16'h0, 1'b0, 4'b1101, 4'h0, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 16'h0, 1'b0, 4'b1011, 4'h0, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 16'h0, 1'b0, 4'b1011, 4'h0, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{1'b1, 16'h0, 1'b0, 4'b1011, 4'h0, 1'b0, 1'b0, 1'b0};
    tbl[12] = '{1'b1, 16'h0, 1'b0, 4'b1011, 4'h0, 1'b0, 1'b0, 1'b0};
    tbl[13] = '{1'b1, 16'h0, 1'b0, 4'b0111, 4'h0, 1'b0, 1'b0, 1'b0};
    tbl[14] = '{1'b1, 16'h0, 1'b1, 4'b0111, 4'h0, 1'b0, 1'b0, 1'b0};
    tbl[15] = '{1'b1, 16'h0, 1'b0, 4'b0111, 4'h0, 1'b0, 1'b0, 1'b0};
    tbl[16] = '{1'b1, 16'h0, 1'b0, 4'b0111, 4'h0, 1'b0, 1'b0, 1'b0};
    tbl[17] = '{1'b1, 16'h0, 1'b0, 4'b1110, 4'h0, 1'b0, 1'b0, 1'b0};
    tbl[18] = '{1'b1, 16'h0, 1'b0, 4'b1110, 4'h0, 1'b0, 1'b0, 1'b0};

    // Single keys, two rows in one column (lowest row wins), two columns
    // (first column scanned after reset wins).
    ktbl[0] = '{16'h0001, 4'h0};
    ktbl[1] = '{16'h8000, 4'hF};
    ktbl[2] = '{16'h0400, 4'hA};
    ktbl[3] = '{16'h0808, 4'h3};
    ktbl[4] = '{16'h2200, 4'h9};
    ktbl[5] = '{16'h0041, 4'h0};

    for (int i = 0; i < 19; i++) begin
      rst_n = tbl[i].rst_v;
      key_ready = tbl[i].rdy;
      set_keys(tbl[i].k);
      tick();
      chk("tbl_col_n", {12'd0, col_n}, {12'd0, tbl[i].e_col_n});
      chk("tbl_code", {12'd0, key_code}, {12'd0, tbl[i].e_code});
      chk("tbl_valid", {15'd0, key_valid}, {15'd0, tbl[i].e_valid});
      chk("tbl_held", {15'd0, key_held}, {15'd0, tbl[i].e_held});
      chk("tbl_ovr", {15'd0, overrun}, {15'd0, tbl[i].e_ovr});
    end
    key_ready = 1'b0;

    for (int i = 0; i < 6; i++) begin
      do_reset();
      set_keys(ktbl[i].k);
      wait_for("ktbl_valid", 1'b0, 1'b1, 60);
      chk("ktbl_code", {12'd0, key_code}, {12'd0, ktbl[i].code});
      chk("ktbl_held", {15'd0, key_held}, 16'd1);
      set_keys(16'h0);
      wait_for("ktbl_release", 1'b1, 1'b0, 40);
      key_ready = 1'b1;
      tick();
      key_ready = 1'b0;
      chk("ktbl_valid_clr", {15'd0, key_valid}, 16'd0);
      chk("ktbl_code_keep", {12'd0, key_code}, {12'd0, ktbl[i].code});
    end

    // Key 9: detected at the column-1 dwell end (edge 8), accepted two dwells later.
    do_reset();
    set_keys(16'h0200);
    repeat (15) tick();
    chk("k9_not_yet", {15'd0, key_valid}, 16'd0);
    tick();
    chk("k9_valid", {15'd0, key_valid}, 16'd1);
    chk("k9_code", {12'd0, key_code}, 16'h9);
    chk("k9_held", {15'd0, key_held}, 16'd1);
    repeat (9) tick();
    chk("k9_col_frozen", {12'd0, col_n}, 16'h000D);
    chk("k9_valid_kept", {15'd0, key_valid}, 16'd1);
    key_ready = 1'b1;
    tick();
    key_ready = 1'b0;
    chk("k9_handshake", {15'd0, key_valid}, 16'd0);
    chk("k9_code_kept", {12'd0, key_code}, 16'h9);

    // Row 0 low for only one dwell of column 3: no key, scanning resumes at column 0.
    do_reset();
    set_keys(16'h0);
    repeat (12) tick();
    chk("glitch_col3", {12'd0, col_n}, 16'h0007);
    set_keys(16'h0008);
    repeat (4) tick();
    chk("glitch_frozen", {12'd0, col_n}, 16'h0007);
    set_keys(16'h0);
    repeat (4) tick();
    chk("glitch_col0", {12'd0, col_n}, 16'h000E);
    chk("glitch_no_valid", {15'd0, key_valid}, 16'd0);
    chk("glitch_no_held", {15'd0, key_held}, 16'd0);

    // Overrun: key 1 unread, released, then key 6 accepted.
    do_reset();
    set_keys(16'h0002);
    wait_for("ovr_k1_valid", 1'b0, 1'b1, 40);
    chk("ovr_k1_code", {12'd0, key_code}, 16'h1);
    set_keys(16'h0);
    wait_for("ovr_k1_release", 1'b1, 1'b0, 40);
    set_keys(16'h0040);
    ovr_cnt = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (overrun === 1'b1) ovr_cnt++;
    end
    chk("ovr_pulse_cycles", 16'(ovr_cnt), 16'd1);
    chk("ovr_code_kept", {12'd0, key_code}, 16'h1);
    chk("ovr_valid_kept", {15'd0, key_valid}, 16'd1);
    chk("ovr_k6_held", {15'd0, key_held}, 16'd1);

    // Rows 1 and 3 on column 0 give key 4; then reset while HELD with valid set.
    do_reset();
    set_keys(16'h1010);
    wait_for("multi_valid", 1'b0, 1'b1, 40);
    chk("multi_code", {12'd0, key_code}, 16'h4);
    chk("rst_pre_held", {15'd0, key_held}, 16'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rst_col_n", {12'd0, col_n}, 16'h000E);
    chk("rst_code", {12'd0, key_code}, 16'h0);
    chk("rst_valid", {15'd0, key_valid}, 16'd0);
    chk("rst_held", {15'd0, key_held}, 16'd0);
    chk("rst_ovr", {15'd0, overrun}, 16'd0);
    ovr_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (overrun === 1'b1) ovr_cnt++;
    end
    chk("rst_no_ovr_after", 16'(ovr_cnt), 16'd0);

    // Random presses, bounces, handshakes and occasional resets vs. the model.
    do_reset();
    hold = 0;
    for (int i = 0; i < 4000; i++) begin
      if (hold == 0) begin
        r = int'($urandom_range(0, 9));
        if (r < 4) mask = 16'h0;
        else if (r < 8) mask = 16'h1 << $urandom_range(0, 15);
        else mask = (16'h1 << $urandom_range(0, 15)) | (16'h1 << $urandom_range(0, 15));
        set_keys(mask);
        hold = int'($urandom_range(3, 60));
      end else begin
        hold--;
      end
      key_ready = ($urandom_range(0, 7) == 0);
      rst_n = ($urandom_range(0, 999) != 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/keypad_scan4x4.md
KEYPAD_SCAN4X4 -- requirements
Module: keypad_scan4x4

Interface
REQ-001 Parameter SCAN_DIV, default 50000, clk cycles each column is strobed (dwell); legal range 4..2^20.
REQ-002 Parameter DEBOUNCE_N, default 20, consecutive matching dwell-end samples needed to accept a press or a release; legal range 1..255.
REQ-003 Port clk  input  1  system clock; all logic on rising edge.
REQ-004 Port rst_n  input  1  reset, synchronous, active-low.
REQ-005 Port col_n  output  4  column strobes, active-low, exactly one bit low at any time.
REQ-006 Port row_n  input  4  row returns, active-low (external pull-ups), asynchronous to clk.
REQ-007 Port key_code  output  4  accepted key, row*4 + column.
REQ-008 Port key_valid  output  1  key_code holds a new key.
REQ-009 Port key_ready  input  1  consumer accepts key_code.
REQ-010 Port key_held  output  1  accepted key still pressed.
REQ-011 Port overrun  output  1  one-cycle pulse, key dropped because key_valid was still high.

Function
REQ-012 row_n SHALL pass through a 2-flop synchronizer; all decisions use the synchronized value row_s.
REQ-013 A dwell counter SHALL count 0..SCAN_DIV-1 and wrap; "dwell end" is the cycle at SCAN_DIV-1; row_s is sampled only at dwell end.
REQ-014 FSM states SHALL be SCAN, DEBOUNCE, HELD, RELEASE.
REQ-015 SCAN: col index advances 0->1->2->3->0 after each dwell end; if any row_s bit is low at dwell end, latch col index and the lowest-index low row, set dbc=1, go DEBOUNCE, freeze col index.
REQ-016 DEBOUNCE: at each dwell end, latched row still low -> dbc+1; when dbc reaches DEBOUNCE_N, accept the key and go HELD; latched row high -> back to SCAN, advancing to the next column.
REQ-017 With DEBOUNCE_N=1 the key SHALL be accepted at the detecting dwell end (DEBOUNCE occupies zero dwells).
REQ-018 Accept: key_code and key_valid update the cycle after the accepting dwell end, if key_valid is low.
REQ-019 Accept while key_valid is high: key_code unchanged, overrun high for exactly one cycle, FSM still goes HELD.
REQ-020 Handshake: key_valid high and key_ready high on a clock edge -> key_valid low next cycle; key_code keeps its value; key_ready ignored while key_valid low.
REQ-021 HELD: key_held=1; at dwell end, latched row high -> go RELEASE with rc=1; otherwise stay.
REQ-022 RELEASE: key_held stays 1; at dwell end, row high -> rc+1, row low -> back to HELD; rc reaching DEBOUNCE_N -> key_held=0, go SCAN, advancing to the next column.
REQ-023 Column frozen in DEBOUNCE/HELD/RELEASE; presses in other columns SHALL be ignored, not queued.
REQ-024 Several rows low in one column: lowest row index wins; only that row is tracked afterwards.
REQ-025 key_code arithmetic SHALL be 4-bit: {row[1:0], col[1:0]}.

Reset
REQ-026 rst_n low at a clock edge SHALL, from the next cycle: state SCAN, col_n=4'b1110, dwell counter/dbc/rc=0, synchronizer=4'b1111, key_code=0, key_valid=0, key_held=0, overrun=0.
REQ-027 Reset in any state, including mid-handshake, SHALL discard the pending key without an overrun pulse.

Verification (SCAN_DIV=4, DEBOUNCE_N=3)
REQ-028 rst_n low 2 cycles, then high, row_n=4'hF -> col_n = 1110,1101,1011,0111, 4 cycles each, repeating; all outputs 0.
REQ-029 row_n[2] low whenever col_n[1] low, key_ready=0 -> key_code=4'h9, key_valid=1 and held, key_held=1, col_n stuck at 1101; key_ready=1 for one cycle -> key_valid=0 next cycle.
REQ-030 row_n[0] low for one dwell of column 3, then high -> no key_valid, scanning resumes at column 0.
REQ-031 Accept key 4'h1 (key_ready=0), release it, press key 4'h6 -> overrun one-cycle pulse, key_code stays 4'h1, key_valid stays 1.
REQ-032 row_n[1] and row_n[3] low on column 0 -> key_code=4'h4.
REQ-033 rst_n low for one edge while in HELD with key_valid=1 -> next cycle all REQ-026 values, with no overrun pulse.
